// File: rtl/multinoc_inject_sched_pkg.sv
// Shared parameters and types for the MultiNoC injection scheduler.
// The tile top and the bench take flit layout and scheduler defaults from here.
package multinoc_inject_sched_pkg;

   localparam int WIDTH_PORT     = 32;
   localparam int POS_VALID      = WIDTH_PORT - 1;
   localparam int INJ_DEPTH      = 4;
   localparam int INJ_STARVE_MAX = 15;

   typedef enum logic {
      SUBNET1 = 1'b0,
      SUBNET2 = 1'b1
   } subnet_e;

   function automatic subnet_e other_subnet(input subnet_e s);
      return (s == SUBNET1) ? SUBNET2 : SUBNET1;
   endfunction

endpackage

// File: rtl/multinoc_inject_sched_fifo.sv
// Small first-word-fall-through FIFO holding core flits until a subnet accepts them.
// Head is read combinationally so the scheduler can select and pop in the same cycle.
module inject_fifo
   import multinoc_inject_sched_pkg::*;
#(
   parameter int DEPTH = INJ_DEPTH,
   parameter int WIDTH = WIDTH_PORT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] din,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW-1:0]    r_wr_ptr;
   logic [AW-1:0]    r_rd_ptr;
   logic [AW:0]      r_count;
   logic             w_push;
   logic             w_pop;

   assign full   = (r_count == (AW + 1)'(DEPTH));
   assign empty  = (r_count == '0);
   assign head   = r_mem[r_rd_ptr];
   assign w_push = push && !full;
   assign w_pop  = pop && !empty;

   // Storage is left unreset; clearing the pointers is enough to discard contents.
   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         if (w_push && !w_pop) begin
            r_count <= r_count + 1'b1;
         end else if (w_pop && !w_push) begin
            r_count <= r_count - 1'b1;
         end
      end
   end

endmodule

// File: rtl/multinoc_inject_sched.sv
// Injection scheduler: buffers core flits and issues one per cycle into subnet 1 or 2,
// round-robin with fallback, with starvation detection and per-subnet injection counters.
module multinoc_inject_sched
   import multinoc_inject_sched_pkg::*;
#(
   parameter int DEPTH      = INJ_DEPTH,
   parameter int STARVE_MAX = INJ_STARVE_MAX
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic [WIDTH_PORT-1:0] core_flit,
   input  logic                  core_valid,
   output logic                  core_ready,
   input  logic                  avail1,
   input  logic                  avail2,
   output logic [WIDTH_PORT-1:0] inj1,
   output logic [WIDTH_PORT-1:0] inj2,
   output logic                  starve,
   output logic [15:0]           cnt1,
   output logic [15:0]           cnt2
);

   logic                  w_full;
   logic                  w_empty;
   logic [WIDTH_PORT-1:0] w_head;
   logic [1:0]            w_avail;
   logic                  w_issue;
   subnet_e               w_sel;
   logic [7:0]            w_block_next;

   subnet_e               r_ptr;
   logic [7:0]            r_block;
   logic                  r_starve;
   logic [WIDTH_PORT-1:0] r_inj1;
   logic [WIDTH_PORT-1:0] r_inj2;
   logic [15:0]           r_cnt1;
   logic [15:0]           r_cnt2;

   inject_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (WIDTH_PORT)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (core_valid),
      .din   (core_flit),
      .pop   (w_issue),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

   assign core_ready = !w_full;
   assign w_avail    = {avail2, avail1};

   // Preferred subnet first, the other one as fallback.
   always_comb begin
      w_issue = 1'b0;
      w_sel   = r_ptr;
      if (!w_empty) begin
         if (w_avail[r_ptr]) begin
            w_issue = 1'b1;
            w_sel   = r_ptr;
         end else if (w_avail[other_subnet(r_ptr)]) begin
            w_issue = 1'b1;
            w_sel   = other_subnet(r_ptr);
         end
      end
   end

   always_comb begin
      w_block_next = r_block;
      if (w_empty || w_issue) begin
         w_block_next = '0;
      end else if (r_block != 8'(STARVE_MAX)) begin
         w_block_next = r_block + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_ptr    <= SUBNET1;
         r_block  <= '0;
         r_starve <= 1'b0;
         r_inj1   <= '0;
         r_inj2   <= '0;
         r_cnt1   <= '0;
         r_cnt2   <= '0;
      end else begin
         r_block  <= w_block_next;
         r_starve <= (w_block_next == 8'(STARVE_MAX));
         r_inj1   <= (w_issue && w_sel == SUBNET1) ? w_head : '0;
         r_inj2   <= (w_issue && w_sel == SUBNET2) ? w_head : '0;
         if (w_issue) begin
            r_ptr <= other_subnet(w_sel);
         end
         if (w_issue && w_sel == SUBNET1 && r_cnt1 != 16'hFFFF) begin
            r_cnt1 <= r_cnt1 + 16'd1;
         end
         if (w_issue && w_sel == SUBNET2 && r_cnt2 != 16'hFFFF) begin
            r_cnt2 <= r_cnt2 + 16'd1;
         end
      end
   end

   assign inj1   = r_inj1;
   assign inj2   = r_inj2;
   assign starve = r_starve;
   assign cnt1   = r_cnt1;
   assign cnt2   = r_cnt2;

endmodule

// File: tb/tb_multinoc_inject_sched.sv
// Directed bench for multinoc_inject_sched: reset, alternation, fallback, backpressure,
// starvation and counter saturation, with hand-computed expectations.
module tb_multinoc_inject_sched;
   import multinoc_inject_sched_pkg::*;

   logic                  clk = 1'b0;
   logic                  reset;
   logic [WIDTH_PORT-1:0] core_flit;
   logic                  core_valid;
   logic                  core_ready;
   logic                  avail1;
   logic                  avail2;
   logic [WIDTH_PORT-1:0] inj1;
   logic [WIDTH_PORT-1:0] inj2;
   logic                  starve;
   logic [15:0]           cnt1;
   logic [15:0]           cnt2;

   int total = 0;
   int bad   = 0;

   logic [31:0] f4 [5];

   always #5 clk = ~clk;

   multinoc_inject_sched dut (
      .clk        (clk),
      .reset      (reset),
      .core_flit  (core_flit),
      .core_valid (core_valid),
      .core_ready (core_ready),
      .avail1     (avail1),
      .avail2     (avail2),
      .inj1       (inj1),
      .inj2       (inj2),
      .starve     (starve),
      .cnt1       (cnt1),
      .cnt2       (cnt2)
   );

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: got %h want %h", tag, obs, exp);
      end
      $display("check %s: got %h want %h", tag, obs, exp);
   endtask

   task automatic do_reset;
      reset      = 1'b1;
      core_valid = 1'b0;
      core_flit  = '0;
      avail1     = 1'b0;
      avail2     = 1'b0;
      tick;
      tick;
      reset = 1'b0;
   endtask

   initial begin
      f4[0] = 32'h8000_0F00;
      f4[1] = 32'h8000_0F01;
      f4[2] = 32'h8000_0F02;
      f4[3] = 32'h8000_0F03;
      f4[4] = 32'h8000_0F04;

      // 1: reset mid-stream discards queued flits
      do_reset;
      check("rst0_ready", core_ready, 1);
      check("rst0_inj1", inj1, 0);
      core_valid = 1'b1;
      core_flit  = 32'h8000_0001; tick;
      core_flit  = 32'h8000_0002; tick;
      core_flit  = 32'h8000_0003; tick;
      core_valid = 1'b0;
      reset = 1'b1; tick; tick; tick;
      reset = 1'b0; tick;
      check("rst_inj1", inj1, 0);
      check("rst_inj2", inj2, 0);
      check("rst_starve", starve, 0);
      check("rst_cnt1", cnt1, 0);
      check("rst_cnt2", cnt2, 0);
      check("rst_ready", core_ready, 1);
      avail1 = 1'b1; avail2 = 1'b1;
      for (int i = 0; i < 4; i++) begin
         tick;
         check("rst_drop_inj1", inj1, 0);
         check("rst_drop_inj2", inj2, 0);
      end

      // 2: round-robin alternation
      do_reset;
      avail1 = 1'b1; avail2 = 1'b1;
      core_valid = 1'b1;
      core_flit = 32'h8000_00A1; tick;
      core_flit = 32'h8000_00B2; tick;
      core_flit = 32'h8000_00C3;
      check("alt_A_inj1", inj1, 32'h8000_00A1);
      check("alt_A_inj2", inj2, 0);
      tick;
      core_flit = 32'h8000_00D4;
      check("alt_B_inj2", inj2, 32'h8000_00B2);
      check("alt_B_inj1", inj1, 0);
      tick;
      core_valid = 1'b0;
      check("alt_C_inj1", inj1, 32'h8000_00C3);
      tick;
      check("alt_D_inj2", inj2, 32'h8000_00D4);
      check("alt_D_inj1", inj1, 0);
      tick;
      check("alt_idle_inj1", inj1, 0);
      check("alt_idle_inj2", inj2, 0);
      check("alt_cnt1", cnt1, 2);
      check("alt_cnt2", cnt2, 2);

      // 3: fallback to subnet 2, then pointer is back on subnet 1
      do_reset;
      avail1 = 1'b0; avail2 = 1'b1;
      core_valid = 1'b1;
      core_flit = 32'h8000_0A0A; tick;
      core_flit = 32'h8000_0B0B; tick;
      core_valid = 1'b0;
      check("fb_A_inj2", inj2, 32'h8000_0A0A);
      check("fb_A_inj1", inj1, 0);
      tick;
      check("fb_B_inj2", inj2, 32'h8000_0B0B);
      tick;
      check("fb_cnt2", cnt2, 2);
      check("fb_cnt1", cnt1, 0);
      avail1 = 1'b1; avail2 = 1'b1;
      core_valid = 1'b1;
      core_flit = 32'h0000_1234; tick;
      core_valid = 1'b0; tick;
      check("fb_ptr_inj1", inj1, 32'h0000_1234);
      check("fb_ptr_inj2", inj2, 0);

      // 4: full FIFO backpressure, then in-order drain
      do_reset;
      core_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         core_flit = f4[i];
         check("full_ready_before", core_ready, 1);
         tick;
      end
      core_flit = f4[4];
      check("full_ready_low", core_ready, 0);
      tick;
      check("full_ready_held", core_ready, 0);
      check("full_no_inj", inj1 | inj2, 0);
      avail1 = 1'b1;
      tick;
      check("full_ready_rise", core_ready, 1);
      check("drain_0", inj1, f4[0]);
      tick;
      core_valid = 1'b0;
      for (int i = 1; i < 5; i++) begin
         check("drain_inj1", inj1, f4[i]);
         check("drain_inj2", inj2, 0);
         tick;
      end
      check("drain_done", inj1, 0);

      // 5: starvation detection
      do_reset;
      core_valid = 1'b1;
      core_flit  = 32'h8000_5555;
      tick;
      core_valid = 1'b0;
      for (int i = 1; i <= 20; i++) begin
         tick;
         check("starve_blk", starve, 32'(i >= 15));
      end
      avail2 = 1'b1;
      tick;
      check("starve_inj2", inj2, 32'h8000_5555);
      check("starve_clear", starve, 0);

      // 6: injection counter saturation
      do_reset;
      avail1     = 1'b1;
      core_valid = 1'b1;
      core_flit  = 32'h8000_6666;
      for (int i = 1; i <= 65545; i++) begin
         tick;
         if (i == 100) check("sat_cnt1_100", cnt1, 99);
         if (i == 65535) check("sat_cnt1_fffe", cnt1, 16'hFFFE);
      end
      core_valid = 1'b0;
      tick; tick; tick;
      check("sat_cnt1", cnt1, 16'hFFFF);
      check("sat_cnt2", cnt2, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
